system_join_ctrl: RTL

//  Child-side join controller; a consumer/producer of system flits (8b system_header_t + 64b system_payload_t).

---
 rtl/system_join_ctrl_pkg.sv | 41 ++++
 rtl/system_join_ctrl_timer.sv | 21 ++
 rtl/system_join_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/system_join_ctrl_pkg.sv
// system_join_ctrl_pkg: system flit types and join controller defaults.
package system_join_ctrl_pkg;
  localparam int JOIN_TIMEOUT_DEFAULT = 1024;
  localparam int JOIN_MAX_RETRY_DEFAULT = 3;
  typedef logic [7:0] node_id_t;
  typedef enum logic [7:0] {
    S_HEARTBEAT                    = 8'h01,
    S_PARENT_REQUEST_FROM_NEIGHBOR = 8'h10,
    S_PARENT_ACK_FROM_NEIGHBOR     = 8'h11,
    S_JOIN_REQUEST                 = 8'h20,
    S_JOIN_ACK                     = 8'h21
  } system_header_t;
  typedef struct packed {
    logic [63:0] rsvd;
  } parent_request_t;
  typedef struct packed {
    node_id_t    parent_id;
    node_id_t    global_id;
    logic [47:0] rsvd;
  } parent_ack_t;
  typedef struct packed {
    node_id_t    random_child_id;
    node_id_t    parent_id;
    logic [47:0] rsvd;
  } join_request_t;
  typedef struct packed {
    node_id_t    random_child_id;
    node_id_t    parent_id;
    node_id_t    child_id;
    logic [39:0] rsvd;
  } join_ack_t;
  typedef union packed {
    parent_request_t parent_request;
    parent_ack_t     parent_ack;
    join_request_t   join_request;
    join_ack_t       join_ack;
  } system_payload_t;
  typedef enum logic [2:0] {
    J_IDLE, J_PREQ, J_PWAIT, J_JREQ, J_JWAIT, J_JOINED, J_FAILED
  } join_state_t;
endpackage

// File: rtl/system_join_ctrl_timer.sv
// join_timeout_timer: counts enabled cycles, pulses expire on the last one.
module join_timeout_timer
  import system_join_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = JOIN_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] count;
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable) count <= count + TIMER_W'(1);
  end
  assign expire = enable && count == LAST;
endmodule

// File: rtl/system_join_ctrl.sv
// system_join_ctrl: child-side parent/join handshake controller publishing acquired ids.
module system_join_ctrl
  import system_join_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = JOIN_TIMEOUT_DEFAULT,
  parameter int MAX_RETRY = JOIN_MAX_RETRY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  random_id,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_header,
  input  logic [63:0] rx_payload,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_header,
  output logic [63:0] tx_payload,
  output logic        busy,
  output logic        joined,
  output logic        failed,
  output logic [7:0]  node_id,
  output logic [7:0]  parent_id,
  output logic [7:0]  global_id
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  join_state_t state, state_n;
  logic [RW-1:0] retry, retry_n;
  node_id_t rid_q, rid_n, pid_n, gid_n, nid_n;
  system_payload_t rx_pl, tx_pl;
  logic waiting, expire, p_ack, j_ack, more, unused_bits;
  assign rx_pl = rx_payload;
  assign waiting = state inside {J_PWAIT, J_JWAIT};
  assign more = retry < MAX_R;
  assign p_ack = rx_valid && rx_header == S_PARENT_ACK_FROM_NEIGHBOR;
  assign j_ack = rx_valid && rx_header == S_JOIN_ACK &&
                 rx_pl.join_ack.random_child_id == rid_q && rx_pl.join_ack.parent_id == parent_id;
  assign unused_bits = ^rx_pl.join_ack.rsvd;
  join_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clear(!waiting), .enable(waiting), .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= J_IDLE;
      retry <= '0;
      rid_q <= '0;
      parent_id <= '0;
      global_id <= '0;
      node_id <= '0;
      rx_ready <= 1'b0;
    end else begin
      state <= state_n;
      retry <= retry_n;
      rid_q <= rid_n;
      parent_id <= pid_n;
      global_id <= gid_n;
      node_id <= nid_n;
      rx_ready <= 1'b1;
    end
  end
  // A matching ack is tested before expire so it wins a same-cycle timeout.
  always_comb begin
    state_n = state;
    retry_n = retry;
    rid_n = rid_q;
    pid_n = parent_id;
    gid_n = global_id;
    nid_n = node_id;
    case (state)
      J_IDLE, J_JOINED, J_FAILED: if (start) begin
        state_n = J_PREQ;
        retry_n = '0;
        pid_n = '0;
        gid_n = '0;
        nid_n = '0;
      end
      J_PREQ: if (tx_ready) state_n = J_PWAIT;
      J_PWAIT: if (p_ack) begin
        state_n = J_JREQ;
        retry_n = '0;
        rid_n = random_id;
        pid_n = rx_pl.parent_ack.parent_id;
        gid_n = rx_pl.parent_ack.global_id;
      end else if (expire) begin
        state_n = more ? J_PREQ : J_FAILED;
        retry_n = more ? retry + RW'(1) : retry;
      end
      J_JREQ: if (tx_ready) state_n = J_JWAIT;
      J_JWAIT: if (j_ack) begin
        state_n = J_JOINED;
        nid_n = rx_pl.join_ack.child_id;
      end else if (expire) begin
        state_n = more ? J_JREQ : J_FAILED;
        retry_n = more ? retry + RW'(1) : retry;
        rid_n = more ? random_id : rid_q;
      end
      default: state_n = J_IDLE;
    endcase
  end
  always_comb begin
    tx_pl = '0;
    if (state == J_JREQ) begin
      tx_pl.join_request.random_child_id = rid_q;
      tx_pl.join_request.parent_id = parent_id;
    end
  end
  assign tx_valid = state == J_PREQ || state == J_JREQ;
  assign tx_header = state == J_PREQ ? S_PARENT_REQUEST_FROM_NEIGHBOR :
                     state == J_JREQ ? S_JOIN_REQUEST : 8'h00;
  assign tx_payload = tx_pl;
  assign busy = !(state inside {J_IDLE, J_JOINED, J_FAILED});
  assign joined = state == J_JOINED;
  assign failed = state == J_FAILED;
endmodule
